// File: rtl/intr_ctrl.sv
// External interrupt sequencer: synchronizes INTR, latches rising edges and
// takes them at precise boundaries with trap redirect, flush and mret return.
module intr_ctrl #(
  parameter int SYNC_STAGES  = 2,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        INTR,
  input  logic        CSR_MIE,
  input  logic [31:0] CSR_MTVEC,
  input  logic [31:0] CSR_MEPC,
  input  logic        INSTR_BOUNDARY,
  input  logic        STALL,
  input  logic [31:0] RETIRE_PC,
  input  logic        MRET_EXEC,
  output logic        INT_TAKEN,
  output logic [31:0] INT_PC,
  output logic        REDIRECT,
  output logic [31:0] REDIRECT_PC,
  output logic        FLUSH,
  output logic        IN_ISR,
  output logic        PENDING
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    TAKE,
    DRAIN,
    ISR
  } state_e;

  localparam logic [3:0] CNT_INIT =
    4'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   vld_q;
  logic                   prev_q;
  logic                   pend_q, pend_d;
  logic                   mret_q, mret_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [31:0]            pc_q, pc_d;

  logic rise;
  logic acc;
  logic mret_acc;

  // vld_q tracks which chain stages hold a real post-reset sample, so a
  // level already high at reset release never looks like an edge
  assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q & vld_q[SYNC_STAGES];
  // the cycle of an mret redirect is not a boundary we may act on
  assign acc      = INSTR_BOUNDARY & ~STALL & ~mret_q;
  assign mret_acc = acc & MRET_EXEC;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    mret_d  = 1'b0;
    pend_d  = rise | (pend_q & (state_q != TAKE));
    case (state_q)
      IDLE: begin
        mret_d = mret_acc;
        if ((pend_q | rise) & CSR_MIE) state_d = ARMED;
      end
      ARMED: begin
        mret_d = mret_acc;
        if (!CSR_MIE) begin
          state_d = IDLE;
        end else if (acc & ~MRET_EXEC) begin
          state_d = TAKE;
          pc_d    = RETIRE_PC;
        end
      end
      TAKE: begin
        if (FLUSH_CYCLES == 1) begin
          state_d = ISR;
        end else begin
          state_d = DRAIN;
          cnt_d   = CNT_INIT;
        end
      end
      DRAIN: begin
        if (cnt_q == 4'd0) state_d = ISR;
        else cnt_d = cnt_q - 4'd1;
      end
      ISR: begin
        mret_d = mret_acc;
        if (mret_acc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sync_q  <= '0;
      vld_q   <= '0;
      prev_q  <= 1'b0;
      pend_q  <= 1'b0;
      mret_q  <= 1'b0;
      cnt_q   <= 4'd0;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], INTR};
      vld_q   <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      prev_q  <= sync_q[SYNC_STAGES-1];
      pend_q  <= pend_d;
      mret_q  <= mret_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    INT_TAKEN   = 1'b0;
    INT_PC      = 32'd0;
    REDIRECT    = mret_q;
    REDIRECT_PC = mret_q ? CSR_MEPC : 32'd0;
    FLUSH       = mret_q;
    IN_ISR      = (state_q == ISR);
    PENDING     = pend_q;
    if (state_q == TAKE) begin
      INT_TAKEN   = 1'b1;
      INT_PC      = pc_q;
      REDIRECT    = 1'b1;
      REDIRECT_PC = {CSR_MTVEC[31:2], 2'b00};
      FLUSH       = 1'b1;
    end
    if (state_q == DRAIN) FLUSH = 1'b1;
  end

endmodule
